intr_ctrl: RTL and testbench

CPU-side receiver for interrupt requests from the button/peripheral interrupt FSMs. Turns each source's request pulse into a sticky pending bit and gates pending requests with the CPU interrupt-enable flag. Presents one prioritized request and source ID to the control unit, and runs the acknowledge/return handshake so ISRs do not nest.

---
 rtl/intr_pkg.sv | 23 ++
 rtl/intr_edge_det.sv | 41 ++++
 rtl/intr_ctrl.sv | 99 +++++++++
 tb/tb_intr_ctrl.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/intr_pkg.sv
// Shared types and constants for the CPU interrupt controller.
// Optional build macro used by the slice: INTR_SYNC_EN (see intr_edge_det).
package intr_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      SERVICE = 1'b1
   } intr_state_t;

   localparam int unsigned INTR_MAX_SRC = 8;

   // Board source assignment; lower index means higher priority.
   localparam int unsigned SRC_BTN0  = 0;
   localparam int unsigned SRC_BTN1  = 1;
   localparam int unsigned SRC_TIMER = 2;
   localparam int unsigned SRC_UART  = 3;

   // Source-ID width, never below one bit.
   function automatic int unsigned intr_id_w(input int unsigned n_src);
      return (n_src > 1) ? $clog2(n_src) : 1;
   endfunction

endpackage

// File: rtl/intr_edge_det.sv
// Per-source rising-edge detector producing a one-cycle event.
// INTR_SYNC_EN: adds a two-flop synchronizer (reset high) ahead of the edge detector.
module intr_edge_det (
   input  logic clk,
   input  logic reset,
   input  logic irq_i,
   output logic evt_c_o
);

   logic irq_s;

`ifdef INTR_SYNC_EN
   logic [1:0] sync_q;

   // Resetting high keeps a source that is already asserted from firing at release.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], irq_i};
      end
   end

   assign irq_s = sync_q[1];
`else
   assign irq_s = irq_i;
`endif

   logic prev_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= irq_s;
      end
   end

   assign evt_c_o = irq_s & ~prev_q;

endmodule

// File: rtl/intr_ctrl.sv
// CPU interrupt receiver: sticky pending bits, fixed priority, enable flag, ack/return FSM.
// INTR_SYNC_EN (optional) inserts input synchronizers inside intr_edge_det.
module intr_ctrl
   import intr_pkg::*;
#(
   parameter  int unsigned N_SRC = 4,
   localparam int unsigned ID_W  = intr_id_w(N_SRC)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] irq_in,
   input  logic             int_set,
   input  logic             int_clr,
   input  logic             int_ack,
   input  logic             int_ret,
   input  logic             int_ret_en,
   output logic             int_req,
   output logic [ID_W-1:0]  int_id,
   output logic             int_en,
   output logic [N_SRC-1:0] pending
);

   intr_state_t      state_q;
   logic             en_q;
   logic [N_SRC-1:0] pending_q;
   logic [N_SRC-1:0] evt_c;
   logic [N_SRC-1:0] clr_mask_c;
   logic [ID_W-1:0]  id_c;
   logic             req_c;
   logic             ack_take_c;

   for (genvar g = 0; g < int'(N_SRC); g++) begin : g_src
      intr_edge_det u_edge_det (
         .clk     (clk),
         .reset   (reset),
         .irq_i   (irq_in[g]),
         .evt_c_o (evt_c[g])
      );
   end

   // Fixed priority: lowest pending index wins, zero when nothing pending.
   always_comb begin
      id_c = '0;
      for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
         if (pending_q[i]) begin
            id_c = ID_W'(i);
         end
      end
   end

   always_comb begin
      req_c      = (state_q == IDLE) & en_q & (|pending_q);
      ack_take_c = int_ack & req_c;
      clr_mask_c = '0;
      if (ack_take_c) begin
         clr_mask_c[id_c] = 1'b1;
      end
   end

   // Later assignments in this block deliberately override earlier ones:
   // ack/return writes of the enable flag beat SEI/CLI, and a fresh event beats the ack clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         en_q      <= 1'b0;
         pending_q <= '0;
      end else begin
         pending_q <= (pending_q & ~clr_mask_c) | evt_c;

         if (int_clr) begin
            en_q <= 1'b0;
         end else if (int_set) begin
            en_q <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (ack_take_c) begin
                  en_q    <= 1'b0;
                  state_q <= SERVICE;
               end
            end
            SERVICE: begin
               if (int_ret) begin
                  en_q    <= int_ret_en;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign int_req = req_c;
   assign int_id  = id_c;
   assign int_en  = en_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// Scoreboard bench for intr_ctrl: directed stimulus pushes expected outputs, a monitor compares them.
module tb_intr_ctrl;

`ifdef INTR_SYNC_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 1;
`endif

   logic       clk;
   logic       reset;
   logic [3:0] irq_in;
   logic       int_set;
   logic       int_clr;
   logic       int_ack;
   logic       int_ret;
   logic       int_ret_en;
   logic       int_req;
   logic [1:0] int_id;
   logic       int_en;
   logic [3:0] pending;

   typedef struct {
      string      name;
      logic       req;
      logic [1:0] id;
      logic       en;
      logic [3:0] pend;
   } exp_t;

   exp_t sb[$];
   int   chk_cnt  = 0;
   int   pass_cnt = 0;

   intr_ctrl #(.N_SRC(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .irq_in     (irq_in),
      .int_set    (int_set),
      .int_clr    (int_clr),
      .int_ack    (int_ack),
      .int_ret    (int_ret),
      .int_ret_en (int_ret_en),
      .int_req    (int_req),
      .int_id     (int_id),
      .int_en     (int_en),
      .pending    (pending)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int got, input int want);
      chk_cnt++;
      if (got == want) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic exp_push(input string n, input logic r, input logic [1:0] i,
                           input logic e, input logic [3:0] p);
      exp_t x;
      x.name = n;
      x.req  = r;
      x.id   = i;
      x.en   = e;
      x.pend = p;
      sb.push_back(x);
   endtask

   // Monitor: outputs are stable mid-cycle; compare against the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk({e.name, ".int_req"}, int'(int_req), int'(e.req));
         chk({e.name, ".int_id"},  int'(int_id),  int'(e.id));
         chk({e.name, ".int_en"},  int'(int_en),  int'(e.en));
         chk({e.name, ".pending"}, int'(pending), int'(e.pend));
      end
   end

   initial begin
      int cnt;
      reset = 1'b1; irq_in = 4'b0001;
      int_set = 1'b0; int_clr = 1'b0; int_ack = 1'b0; int_ret = 1'b0; int_ret_en = 1'b0;
      tick();
      exp_push("in_reset", 1'b0, 2'd0, 1'b0, 4'b0000);
      tick();
      reset = 1'b0;
      tick();
      exp_push("reset_release", 1'b0, 2'd0, 1'b0, 4'b0000);
      int_set = 1'b1; tick(); int_set = 1'b0;
      exp_push("held_high_no_event", 1'b0, 2'd0, 1'b1, 4'b0000);

`ifndef INTR_SYNC_EN
      irq_in = 4'b0000; tick();
      exp_push("drop_src0", 1'b0, 2'd0, 1'b1, 4'b0000);
      irq_in = 4'b0001; tick();
      exp_push("rise_src0", 1'b1, 2'd0, 1'b1, 4'b0001);
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      exp_push("ack_src0", 1'b0, 2'd0, 1'b0, 4'b0000);
      irq_in = 4'b0000; int_ret = 1'b1; int_ret_en = 1'b1; tick(); int_ret = 1'b0;
      exp_push("retie_empty", 1'b0, 2'd0, 1'b1, 4'b0000);

      irq_in = 4'b0110; tick(); irq_in = 4'b0000;
      exp_push("two_src", 1'b1, 2'd1, 1'b1, 4'b0110);
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      exp_push("ack_src1", 1'b0, 2'd2, 1'b0, 4'b0100);
      int_ret = 1'b1; int_ret_en = 1'b1; tick(); int_ret = 1'b0;
      exp_push("retie_src2", 1'b1, 2'd2, 1'b1, 4'b0100);
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      exp_push("ack_src2", 1'b0, 2'd0, 1'b0, 4'b0000);

      irq_in = 4'b1000; int_set = 1'b1; tick(); irq_in = 4'b0000; int_set = 1'b0;
      exp_push("set_in_service", 1'b0, 2'd3, 1'b1, 4'b1000);
      int_ret = 1'b1; int_ret_en = 1'b0; tick(); int_ret = 1'b0;
      exp_push("retid", 1'b0, 2'd3, 1'b0, 4'b1000);
      int_ret = 1'b1; int_ret_en = 1'b1; tick(); int_ret = 1'b0;
      exp_push("ret_in_idle", 1'b0, 2'd3, 1'b0, 4'b1000);

      irq_in = 4'b0001; tick(); irq_in = 4'b0000;
      exp_push("pend_disabled", 1'b0, 2'd0, 1'b0, 4'b1001);
      int_set = 1'b1; tick(); int_set = 1'b0;
      exp_push("enable_src0", 1'b1, 2'd0, 1'b1, 4'b1001);
      int_ack = 1'b1; irq_in = 4'b0001; tick(); int_ack = 1'b0; irq_in = 4'b0000;
      exp_push("ack_vs_event", 1'b0, 2'd0, 1'b0, 4'b1001);
      int_ret = 1'b1; int_ret_en = 1'b1; tick(); int_ret = 1'b0;
      exp_push("retie_src0", 1'b1, 2'd0, 1'b1, 4'b1001);

      int_set = 1'b1; int_clr = 1'b1; tick(); int_set = 1'b0; int_clr = 1'b0;
      exp_push("set_clr", 1'b0, 2'd0, 1'b0, 4'b1001);
      int_ack = 1'b1; tick(); int_ack = 1'b0;
      exp_push("ack_ignored", 1'b0, 2'd0, 1'b0, 4'b1001);
      int_set = 1'b1; tick(); int_set = 1'b0;
      exp_push("still_idle", 1'b1, 2'd0, 1'b1, 4'b1001);

      int_ack = 1'b1; tick(); int_ack = 1'b0;
      exp_push("ack_src0_b", 1'b0, 2'd3, 1'b0, 4'b1000);
      irq_in = 4'b0010; tick(); irq_in = 4'b0000;
      exp_push("accum", 1'b0, 2'd1, 1'b0, 4'b1010);
      reset = 1'b1; tick(); reset = 1'b0;
      exp_push("reset_service", 1'b0, 2'd0, 1'b0, 4'b0000);
      int_set = 1'b1; tick(); int_set = 1'b0;
      exp_push("post_reset_en", 1'b0, 2'd0, 1'b1, 4'b0000);
      irq_in = 4'b0100; tick(); irq_in = 4'b0000;
      exp_push("post_reset_idle", 1'b1, 2'd2, 1'b1, 4'b0100);

      int_ack = 1'b1; tick(); int_ack = 1'b0;
      exp_push("ack_src2_b", 1'b0, 2'd0, 1'b0, 4'b0000);
      int_ret = 1'b1; int_ret_en = 1'b1; int_clr = 1'b1; tick(); int_ret = 1'b0; int_clr = 1'b0;
      exp_push("ret_over_clr", 1'b0, 2'd0, 1'b1, 4'b0000);
      irq_in = 4'b0001; tick(); irq_in = 4'b0000;
      exp_push("rise_src0_b", 1'b1, 2'd0, 1'b1, 4'b0001);
      int_ack = 1'b1; int_set = 1'b1; tick(); int_ack = 1'b0; int_set = 1'b0;
      exp_push("ack_over_set", 1'b0, 2'd0, 1'b0, 4'b0000);
      int_ret = 1'b1; int_ret_en = 1'b1; tick(); int_ret = 1'b0;
      exp_push("retie_final", 1'b0, 2'd0, 1'b1, 4'b0000);
`endif

      // Event-to-request latency, measured from the edge that first samples the rise.
      irq_in = 4'b0000;
      repeat (3) tick();
      irq_in = 4'b0100;
      cnt = 0;
      while (cnt < 10) begin
         tick();
         cnt++;
         if (int_req) break;
      end
      chk("latency", cnt, LAT);
      irq_in = 4'b0000;

      cnt = 0;
      while (sb.size() > 0 && cnt < 20) begin
         tick();
         cnt++;
      end
      chk("scoreboard_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule
